leaf_out_arbiter: RTL and testbench

- Shares the single leaf-to-BFT output link among NUM_REQ packet sources, e.g. the user output-port streams plus the config/freespace-update source.
- Round-robin arbitration with bounded bursts and a registered output stage.
- Honours the BFT resend back-pressure by re-presenting the held packet.
- Sits between the per-port packetizers and the Extract_Control stream_in path.

---
 rtl/leaf_if_pkg.sv | 13 +
 rtl/leaf_out_arbiter_if.sv | 28 ++
 rtl/rr_priority_pick.sv | 43 ++++
 rtl/leaf_out_arbiter.sv | 108 ++++++++++
 tb/tb_leaf_out_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/leaf_if_pkg.sv
// Shared constants and state encodings for the leaf output arbiter.
package leaf_if_pkg;

  localparam int PACKET_BITS = 49;
  localparam int VLD_BIT     = PACKET_BITS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// Request/response bundle between the packet sources, the arbiter and the BFT link.
interface leaf_out_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = 2
);
  import leaf_if_pkg::*;

  logic [NUM_REQ-1:0]             req_vld;
  logic [PACKET_BITS*NUM_REQ-1:0] req_pkt;
  logic [NUM_REQ-1:0]             req_ack;
  logic                           resend;
  logic [PACKET_BITS-1:0]         dout;
  logic [REQ_BITS-1:0]            grant_id;
  logic                           busy;

  // Sources and BFT side: drive requests and back-pressure, observe the link.
  modport master (
    output req_vld, req_pkt, resend,
    input  req_ack, dout, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req_vld, req_pkt, resend,
    output req_ack, dout, grant_id, busy
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: first set request after ptr, wrapping around.
module rr_priority_pick #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [REQ_BITS-1:0] idx,
  output logic                any
);

  logic [NUM_REQ-1:0] rot_s;
  int                 off_s;
  int                 sum_s;

  // Rotate the doubled mask so bit 0 is requester ptr+1, find the lowest set bit, map back.
  always_comb begin
    rot_s = NUM_REQ'({req, req} >> (int'(ptr) + 1));
    off_s = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = k;
      end else begin
        off_s = off_s;
      end
    end
    sum_s = int'(ptr) + 1 + off_s;
    if (sum_s >= NUM_REQ) begin
      sum_s = sum_s - NUM_REQ;
    end else begin
      sum_s = sum_s;
    end
    any = |req;
    idx = REQ_BITS'(sum_s);
    if (any) begin
      grant = NUM_REQ'(1'b1) << sum_s;
    end else begin
      grant = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, burst-bounded arbiter onto the single leaf-to-BFT output link.
// The link stage is registered; resend re-presents the held packet.
module leaf_out_arbiter
  import leaf_if_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int REQ_BITS   = 2,
  parameter int MAX_BURST  = 4,
  parameter int BURST_BITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  leaf_out_arbiter_if.slave bus
);

  arb_state_e              state_r, state_nxt_s;
  logic [REQ_BITS-1:0]     ptr_r, ptr_nxt_s;
  logic [REQ_BITS-1:0]     gid_r, gid_nxt_s;
  logic [BURST_BITS-1:0]   cnt_r, cnt_nxt_s;
  logic [PACKET_BITS-1:0]  dout_r, dout_nxt_s, sel_pkt_s;
  logic                    busy_r;
  logic [NUM_REQ-1:0]      ack_s, pick_grant_s;
  logic [REQ_BITS-1:0]     pick_idx_s, sel_idx_s;
  logic                    pick_any_s, hold_s, keep_s, sel_vld_s;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .REQ_BITS (REQ_BITS)
  ) u_pick (
    .req   (bus.req_vld),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Selection, next-state and next output stage; a zero counter means no burst in progress.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    gid_nxt_s   = gid_r;
    dout_nxt_s  = dout_r;
    ack_s       = {NUM_REQ{1'b0}};
    sel_vld_s   = 1'b0;
    sel_idx_s   = ptr_r;
    hold_s      = bus.resend && (state_r != IDLE);
    keep_s      = (cnt_r != {BURST_BITS{1'b0}}) &&
                  (cnt_r < BURST_BITS'(MAX_BURST)) && bus.req_vld[ptr_r];

    if (hold_s) begin
      state_nxt_s = HOLD;
    end else if (keep_s) begin
      sel_vld_s = 1'b1;
      sel_idx_s = ptr_r;
      cnt_nxt_s = cnt_r + BURST_BITS'(1);
      ack_s     = NUM_REQ'(1'b1) << ptr_r;
    end else if (pick_any_s) begin
      sel_vld_s = 1'b1;
      sel_idx_s = pick_idx_s;
      cnt_nxt_s = BURST_BITS'(1);
      ptr_nxt_s = pick_idx_s;
      ack_s     = pick_grant_s;
    end else begin
      cnt_nxt_s = {BURST_BITS{1'b0}};
    end

    sel_pkt_s = bus.req_pkt[int'(sel_idx_s)*PACKET_BITS +: PACKET_BITS];

    if (hold_s) begin
      dout_nxt_s = dout_r;
    end else if (sel_vld_s) begin
      dout_nxt_s          = sel_pkt_s;
      dout_nxt_s[VLD_BIT] = 1'b1;
      gid_nxt_s           = sel_idx_s;
      state_nxt_s         = SEND;
    end else begin
      dout_nxt_s  = {PACKET_BITS{1'b0}};
      gid_nxt_s   = {REQ_BITS{1'b0}};
      state_nxt_s = IDLE;
    end
  end

  // State, pointer, burst counter and registered link stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= REQ_BITS'(NUM_REQ - 1);
      cnt_r   <= {BURST_BITS{1'b0}};
      gid_r   <= {REQ_BITS{1'b0}};
      dout_r  <= {PACKET_BITS{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      gid_r   <= gid_nxt_s;
      dout_r  <= dout_nxt_s;
      busy_r  <= dout_nxt_s[VLD_BIT];
    end
  end

  assign bus.req_ack  = reset ? {NUM_REQ{1'b0}} : ack_s;
  assign bus.dout     = dout_r;
  assign bus.grant_id = gid_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: vector table plus multi-cycle sequences.
module tb_leaf_out_arbiter;
  import leaf_if_pkg::*;

  localparam int NR = 4;
  localparam int RB = 2;
  localparam int NV = 23;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NR-1:0]             vld = '0;
  logic [PACKET_BITS*NR-1:0] pkts = '0;
  logic                      rs = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  leaf_out_arbiter_if #(.NUM_REQ(NR), .REQ_BITS(RB)) bus0 ();
  leaf_out_arbiter_if #(.NUM_REQ(NR), .REQ_BITS(RB)) bus1 ();

  assign bus0.req_vld = vld;
  assign bus0.req_pkt = pkts;
  assign bus0.resend  = rs;
  assign bus1.req_vld = vld;
  assign bus1.req_pkt = pkts;
  assign bus1.resend  = rs;

  leaf_out_arbiter #(.NUM_REQ(NR), .REQ_BITS(RB), .MAX_BURST(4), .BURST_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  leaf_out_arbiter #(.NUM_REQ(NR), .REQ_BITS(RB), .MAX_BURST(1), .BURST_BITS(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  typedef struct {
    bit        rst;
    logic [3:0] vld;
    bit        rs;
    logic [3:0] ack;
    bit        dv;
    int        src;
  } vec_t;

  vec_t tbl [NV];

  function automatic logic [48:0] base_pkt(input int i);
    logic [47:0] lo;
    lo = 48'h5A5A_0000_0000 | 48'(i * 17 + 3);
    return {1'b0, lo};
  endfunction

  function automatic logic [48:0] exp_dout(input int src, input bit dv);
    logic [48:0] e;
    e = base_pkt(src);
    e[48] = 1'b1;
    return dv ? e : 49'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_base();
    for (int i = 0; i < NR; i++) pkts[i*PACKET_BITS +: PACKET_BITS] = base_pkt(i);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    vld   = '0;
    rs    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // rst, vld, resend, expected ack, dout valid, dout source
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 0};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};
    tbl[3]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, 0};
    tbl[4]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2};
    tbl[5]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2};
    tbl[6]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2};
    tbl[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2};
    tbl[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};
    tbl[12] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b0, 0};
    tbl[13] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 0};
    tbl[14] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 0};
    tbl[15] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 0};
    tbl[16] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 0};
    tbl[17] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 3};
    tbl[18] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 3};
    tbl[19] = '{1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 3};
    tbl[20] = '{1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1, 3};
    tbl[21] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 0};
    tbl[22] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};

    load_base();
    @(negedge clk);

    // Table: reset/idle, single requester, burst limit with rotation.
    for (int k = 0; k < NV; k++) begin
      reset = tbl[k].rst;
      vld   = tbl[k].vld;
      rs    = tbl[k].rs;
      #1;
      chk($sformatf("v%0d ack", k), 64'(bus0.req_ack), 64'(tbl[k].ack));
      chk($sformatf("v%0d dout", k), 64'(bus0.dout), 64'(exp_dout(tbl[k].src, tbl[k].dv)));
      chk($sformatf("v%0d busy", k), 64'(bus0.busy), 64'(tbl[k].dv));
      if (tbl[k].dv || tbl[k].rst || k < 3)
        chk($sformatf("v%0d gid", k), 64'(bus0.grant_id), 64'(tbl[k].src));
      @(negedge clk);
    end

    // Round robin with MAX_BURST=1: ack order 0,1,2,3,0,1.
    reset_pulse();
    begin
      int order [6];
      order = '{0, 1, 2, 3, 0, 1};
      for (int c = 0; c < 6; c++) begin
        vld = 4'b1111;
        #1;
        chk($sformatf("rr%0d ack", c), 64'(bus1.req_ack), 64'(4'b0001 << order[c]));
        if (c > 0) begin
          chk($sformatf("rr%0d dout", c), 64'(bus1.dout), 64'(exp_dout(order[c-1], 1'b1)));
          chk($sformatf("rr%0d gid", c), 64'(bus1.grant_id), 64'(order[c-1]));
        end
        @(negedge clk);
      end
    end

    // Resend: held packet re-presented, no acks, then the next packet follows.
    reset_pulse();
    pkts[1*PACKET_BITS +: PACKET_BITS] = 49'h1_0000_0000_00AB;
    vld = 4'b0010;
    rs  = 1'b1;
    #1;
    chk("rs idle ack", 64'(bus0.req_ack), 64'(4'b0010));
    @(negedge clk);
    pkts[1*PACKET_BITS +: PACKET_BITS] = 49'h0_0000_0000_00CD;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rs%0d ack", c), 64'(bus0.req_ack), 64'(4'b0000));
      chk($sformatf("rs%0d dout", c), 64'(bus0.dout), 64'(49'h1_0000_0000_00AB));
      chk($sformatf("rs%0d gid", c), 64'(bus0.grant_id), 64'(1));
      @(negedge clk);
    end
    rs = 1'b0;
    #1;
    chk("rs drop ack", 64'(bus0.req_ack), 64'(4'b0010));
    chk("rs drop dout", 64'(bus0.dout), 64'(49'h1_0000_0000_00AB));
    @(negedge clk);
    vld = 4'b0000;
    #1;
    chk("rs next dout", 64'(bus0.dout), 64'(49'h1_0000_0000_00CD));
    chk("rs next busy", 64'(bus0.busy), 64'(1));
    chk("rs next ack", 64'(bus0.req_ack), 64'(4'b0000));
    @(negedge clk);
    load_base();

    // Reset in the middle of a burst from requester 3.
    reset_pulse();
    vld = 4'b1000;
    #1;
    chk("mb ack0", 64'(bus0.req_ack), 64'(4'b1000));
    @(negedge clk);
    #1;
    chk("mb ack1", 64'(bus0.req_ack), 64'(4'b1000));
    chk("mb dout1", 64'(bus0.dout), 64'(exp_dout(3, 1'b1)));
    @(negedge clk);
    #1;
    chk("mb dout2", 64'(bus0.dout), 64'(exp_dout(3, 1'b1)));
    reset = 1'b1;
    #1;
    chk("mb rst dout", 64'(bus0.dout), 64'(49'h0));
    chk("mb rst busy", 64'(bus0.busy), 64'(0));
    chk("mb rst ack", 64'(bus0.req_ack), 64'(4'b0000));
    @(negedge clk);
    reset = 1'b0;
    vld   = 4'b1111;
    #1;
    chk("mb rel ack", 64'(bus0.req_ack), 64'(4'b0001));
    chk("mb rel dout", 64'(bus0.dout), 64'(49'h0));
    @(negedge clk);
    #1;
    chk("mb rel dout1", 64'(bus0.dout), 64'(exp_dout(0, 1'b1)));
    chk("mb rel gid1", 64'(bus0.grant_id), 64'(0));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
